vc_arbiter: RTL
===============

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
- REQ-001: Parameter data_width, default 6, word width; bit [data_width-1] is the destination select (0 = D0, 1 = D1).
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge clears all state.
- REQ-004: init  input  1  0 = configuration phase; 1 = run.
- REQ-005: weight_vc0  input  4  VC0 words per turn; sampled only during configuration; 0 is treated as 1.
- REQ-006: weight_vc1  input  4  VC1 words per turn; same rules as weight_vc0.
- REQ-007: vc0_empty, vc1_empty  input  1 each  VC FIFO empty flags.
- REQ-008: vc0_data, vc1_data  input  data_width each  head word of each first-word-fall-through VC FIFO; valid while not empty.
- REQ-009: d0_almost_full, d1_almost_full  input  1 each  destination FIFO almost-full flags.
- REQ-010: vc0_pop, vc1_pop  output  1 each  combinational pops; consume the head word on the same edge.
- REQ-011: d0_push, d1_push  output  1 each  registered destination push strobes.
- REQ-012: data_out  output  data_width  registered word that accompanies d0_push/d1_push.
- REQ-013: idle_out, active_out  output  1 each  registered state indicators.

Function
- REQ-014: The FSM SHALL have three states: INIT, IDLE and ACTIVE.
- REQ-015: INIT, init=0: stay in INIT; load weight_vc0 and weight_vc1 into the weight registers every cycle; issue no pops.
- REQ-016: INIT, init=1: go to IDLE; the weight registers freeze at the values held in the last INIT cycle.
- REQ-017: In IDLE or ACTIVE, init returning to 0 SHALL return the FSM to INIT on the next edge; any word already in flight is still pushed.
- REQ-018: Eligibility: VCx is eligible iff vcx_empty=0 and the almost_full flag of the destination selected by vcx_data[data_width-1] is 0.
- REQ-019: Selection: the current VC (cur) if eligible, else the other VC if eligible, else none; at most one pop per cycle.
- REQ-020: Turn accounting when VC s is granted:
  - c = cnt if s==cur, else weight_s;
  - if c==1: cur <= other VC and cnt <= weight of the other VC;
  - else: cur <= s and cnt <= c-1.
  With no grant, cur and cnt hold.
- REQ-021: A grant SHALL assert pop_s combinationally in the same cycle, and the FSM SHALL be in IDLE or ACTIVE in that cycle.
- REQ-022: On the grant edge, the popped word SHALL be registered into data_out.
- REQ-023: In the following cycle, exactly one of d0_push/d1_push SHALL assert, chosen by data_out[data_width-1]; latency is 1 cycle.
- REQ-024: In a cycle with no grant, d0_push and d1_push SHALL be 0 in the next cycle, and data_out SHALL hold its value.
- REQ-025: FSM transitions between IDLE and ACTIVE:
  - IDLE -> ACTIVE on the edge of a grant;
  - ACTIVE -> IDLE on the edge of a cycle with no grant.
  - idle_out = (state==IDLE); active_out = (state==ACTIVE); both are 0 in INIT.
- REQ-026: Almost-full is evaluated only against the head word. Destination FIFOs SHALL assert almost_full with at least 1 free slot, to absorb the one in-flight word.
- REQ-027: Simultaneous events:
  - both VCs eligible: cur wins;
  - cur ineligible: the other VC is granted immediately, with no lost cycle;
  - both destinations almost full: no grant, and the state holds.
- REQ-028: Credit counter: cnt is 4 bits and never wraps; the value 0 is unreachable after the weight-0 -> 1 mapping.

Reset
- REQ-029: When reset=0 is sampled, the block SHALL enter this state on that edge, overriding all other inputs:
  - state=INIT, cur=VC0, cnt=1, both weight registers=1;
  - data_out=0; all pops, pushes, idle_out and active_out = 0.
- REQ-030: Reset asserted mid-transfer SHALL drop any in-flight push (no push in the following cycle).
- REQ-031: After reset deassertion, the block SHALL remain in INIT until it samples init=1.

Verification
- REQ-032: Reset/config: reset=0 for 4 cycles, then reset=1, init=0, weights 2/1, then init=1 -> all outputs 0; idle_out=1 one cycle after init=1.
- REQ-033: Weighted round-robin: both VCs non-empty, weights 2/1 -> pop sequence VC0,VC0,VC1,VC0,VC0,VC1; pushes follow each pop 1 cycle later with the matching data_out.
- REQ-034: Routing: VC0 head 6'b000101 then VC1 head 6'b110110 -> d0_push with data_out=6'b000101, then d1_push with data_out=6'b110110.
- REQ-035: Backpressure: d1_almost_full=1 while the VC0 head targets D1 and the VC1 head targets D0 -> VC1 popped every cycle and VC0 never popped until d1_almost_full=0.
- REQ-036: Weight 0: weights 0/3 -> sequence VC0,VC1,VC1,VC1,VC0; empty on both VCs -> ACTIVE->IDLE after one idle cycle.
- REQ-037: Reset mid-burst: reset=0 during a VC1 grant -> no push in the next cycle; state INIT; cur=VC0.

Source files
------------

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - weighted round-robin arbiter moving words from two VC FIFOs to two destination FIFOs
module vc_arbiter #(
    parameter int data_width = 6                  // word width; msb selects destination (0 = D0, 1 = D1)
) (
    input  logic                  clk,            // single clock
    input  logic                  reset,          // synchronous, active-low
    input  logic                  init,           // 0 = configuration, 1 = run
    input  logic [3:0]            weight_vc0,     // VC0 words per turn (0 treated as 1)
    input  logic [3:0]            weight_vc1,     // VC1 words per turn (0 treated as 1)
    input  logic                  vc0_empty,      // VC0 FIFO empty
    input  logic                  vc1_empty,      // VC1 FIFO empty
    input  logic [data_width-1:0] vc0_data,       // VC0 head word (first-word-fall-through)
    input  logic [data_width-1:0] vc1_data,       // VC1 head word (first-word-fall-through)
    input  logic                  d0_almost_full, // destination 0 almost full
    input  logic                  d1_almost_full, // destination 1 almost full
    output logic                  vc0_pop,        // combinational pop of VC0 head
    output logic                  vc1_pop,        // combinational pop of VC1 head
    output logic                  d0_push,        // registered push into destination 0
    output logic                  d1_push,        // registered push into destination 1
    output logic [data_width-1:0] data_out,       // registered word accompanying the push
    output logic                  idle_out,       // registered: state is IDLE
    output logic                  active_out      // registered: state is ACTIVE
);

    localparam int MSB = data_width - 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                state;
    logic                  cur;        // VC that currently owns the turn
    logic [3:0]            cnt;        // words left in the current turn
    logic [3:0]            w0_q;
    logic [3:0]            w1_q;

    logic                  elig0;
    logic                  elig1;
    logic                  cur_elig;
    logic                  oth_elig;
    logic                  grant;
    logic                  sel;
    logic [3:0]            sel_w;
    logic [3:0]            oth_w;
    logic [3:0]            c_eff;
    logic [3:0]            w0_in;
    logic [3:0]            w1_in;
    logic [data_width-1:0] grant_data;

    always_comb begin
        elig0    = 1'b0;
        elig1    = 1'b0;
        cur_elig = 1'b0;
        oth_elig = 1'b0;
        grant    = 1'b0;
        sel      = 1'b0;
        sel_w    = 4'd1;
        oth_w    = 4'd1;
        c_eff    = 4'd1;
        w0_in    = 4'd1;
        w1_in    = 4'd1;
        grant_data = '0;
        vc0_pop  = 1'b0;
        vc1_pop  = 1'b0;

        // Only the head word is looked at: its destination must have room.
        elig0 = !vc0_empty && !(vc0_data[MSB] ? d1_almost_full : d0_almost_full);
        elig1 = !vc1_empty && !(vc1_data[MSB] ? d1_almost_full : d0_almost_full);

        cur_elig = cur ? elig1 : elig0;
        oth_elig = cur ? elig0 : elig1;

        // Pops are gated by reset so a word is never consumed on an edge that discards it.
        grant = reset && (state != ST_INIT) && (cur_elig || oth_elig);
        sel   = cur_elig ? cur : ~cur;

        sel_w = sel ? w1_q : w0_q;
        oth_w = sel ? w0_q : w1_q;
        // A VC taking over from the other starts a fresh turn at its full weight.
        c_eff = (sel == cur) ? cnt : sel_w;

        grant_data = sel ? vc1_data : vc0_data;
        vc0_pop    = grant && !sel;
        vc1_pop    = grant && sel;

        w0_in = (weight_vc0 == 4'd0) ? 4'd1 : weight_vc0;
        w1_in = (weight_vc1 == 4'd0) ? 4'd1 : weight_vc1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_INIT;
            cur        <= 1'b0;
            cnt        <= 4'd1;
            w0_q       <= 4'd1;
            w1_q       <= 4'd1;
            data_out   <= '0;
            d0_push    <= 1'b0;
            d1_push    <= 1'b0;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            d0_push <= grant && !grant_data[MSB];
            d1_push <= grant && grant_data[MSB];
            if (grant) begin
                data_out <= grant_data;
                if (c_eff == 4'd1) begin
                    cur <= ~sel;
                    cnt <= oth_w;
                end else begin
                    cur <= sel;
                    cnt <= c_eff - 4'd1;
                end
            end

            case (state)
                ST_INIT: begin
                    // Run always starts with VC0 owning a full turn.
                    cur <= 1'b0;
                    if (!init) begin
                        w0_q       <= w0_in;
                        w1_q       <= w1_in;
                        cnt        <= w0_in;
                        idle_out   <= 1'b0;
                        active_out <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        cnt        <= w0_q;
                        idle_out   <= 1'b1;
                        active_out <= 1'b0;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (!init) begin
                        state      <= ST_INIT;
                        idle_out   <= 1'b0;
                        active_out <= 1'b0;
                    end else if (grant) begin
                        state      <= ST_ACTIVE;
                        idle_out   <= 1'b0;
                        active_out <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        idle_out   <= 1'b1;
                        active_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_INIT;
                    idle_out   <= 1'b0;
                    active_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
